ej32_rstack: RTL and testbench

//  Return-stack unit for eJ32: the receiving end of the AU's pushr path and the source for its popr/dupr path.

---
 rtl/ej32_rstack_pkg.sv | 4 +
 rtl/ej32_rstack_if.sv | 18 +
 rtl/ej32_rstack_bram_dp.sv | 18 +
 rtl/ej32_rstack.sv | 90 +++++++++
 tb/tb_ej32_rstack.sv | 134 +++++++++++++
 5 files changed

// File: rtl/ej32_rstack_pkg.sv
// ej32_rstack_pkg: return-stack op encoding shared by the unit, its controller and the bench
package ej32_rstack_pkg;
  typedef enum logic [2:0] {rNOP, rPUSH, rPOP, rDEC, rCLR} rs_op_t;
endpackage

// File: rtl/ej32_rstack_if.sv
// ej32_rstack_if: controller-side op/data bus and status outputs of the return stack
interface ej32_rstack_if
  import ej32_rstack_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int ASZ = 5
);
  logic           en;
  rs_op_t         op;
  logic [DSZ-1:0] d_i;
  logic [DSZ-1:0] r_o;
  logic           z_o;
  logic [ASZ:0]   depth_o;
  logic           ovf_o;
  logic           udf_o;
  modport master (output en, op, d_i, input r_o, z_o, depth_o, ovf_o, udf_o);
  modport slave (input en, op, d_i, output r_o, z_o, depth_o, ovf_o, udf_o);
endinterface

// File: rtl/ej32_rstack_bram_dp.sv
// bram_dp: simple dual-port EBR clocked on the falling edge so reads land before the next posedge
module bram_dp #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always_ff @(negedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ej32_rstack.sv
// ej32_rstack: eJ32 return stack; top entry in r_o, deeper entries spilled to a negedge EBR
module ej32_rstack
  import ej32_rstack_pkg::*;
#(
  parameter int RS_DEPTH = 32,
  parameter int DSZ      = 32,
  parameter int ASZ      = $clog2(RS_DEPTH)
) (
  input logic clk,
  input logic rst,
  ej32_rstack_if.slave rs
);
  localparam logic [ASZ:0] FULL = (ASZ+1)'(RS_DEPTH);
  localparam logic [ASZ:0] ONE  = (ASZ+1)'(1);
  logic [ASZ-1:0] rp, rp_n, rd_addr;
  logic [ASZ:0]   dep, dep_n;
  logic [DSZ-1:0] r, r_n, rd_q;
  logic           z, z_n, ovf, ovf_n, udf, udf_n, wr_en, pop;
  assign rd_addr = rp - 1'b1;
  bram_dp #(.DW(DSZ), .AW(ASZ)) u_mem (
    .clk(clk), .wr_en(wr_en), .wr_addr(rp), .wr_data(r),
    .rd_addr(rd_addr), .rd_data(rd_q)
  );
  always_comb begin
    r_n = r;
    rp_n = rp;
    dep_n = dep;
    z_n = z;
    ovf_n = ovf;
    udf_n = udf;
    wr_en = 1'b0;
    pop = 1'b0;
    if (rs.en) begin
      z_n = 1'b0;
      case (rs.op)
        rPUSH: if (dep == FULL) ovf_n = 1'b1;
               else begin
                 wr_en = !rst && dep != '0;
                 rp_n = dep != '0 ? rp + 1'b1 : rp;
                 r_n = rs.d_i;
                 dep_n = dep + 1'b1;
               end
        rPOP:  if (dep == '0) udf_n = 1'b1; else pop = 1'b1;
        rDEC:  if (dep == '0) udf_n = 1'b1;
               else if (r != '0) r_n = r - 1'b1;
               else begin
                 pop = 1'b1;
                 z_n = 1'b1;
               end
        rCLR:  begin
                 rp_n = '0;
                 dep_n = '0;
                 r_n = '0;
               end
        default: ;
      endcase
      if (pop) begin
        r_n = dep == ONE ? '0 : rd_q;
        rp_n = dep == ONE ? rp : rp - 1'b1;
        dep_n = dep - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      rp <= '0;
      dep <= '0;
      z <= 1'b0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      r <= r_n;
      rp <= rp_n;
      dep <= dep_n;
      z <= z_n;
      ovf <= ovf_n;
      udf <= udf_n;
    end
  end
  // spill and refill addresses are rp and rp-1, so they can never collide
  always_ff @(negedge clk) begin
    if (wr_en) assert (rp != rd_addr);
  end
  assign rs.r_o = r;
  assign rs.z_o = z;
  assign rs.depth_o = dep;
  assign rs.ovf_o = ovf;
  assign rs.udf_o = udf;
endmodule

// File: tb/tb_ej32_rstack.sv
// tb_ej32_rstack: directed vectors against a queue model of the return stack
module tb_ej32_rstack;
  import ej32_rstack_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int miss = 0;
  logic [31:0] q[$];
  logic mz = 1'b0, movf = 1'b0, mudf = 1'b0;
  ej32_rstack_if #(.DSZ(32), .ASZ(5)) bus ();
  ej32_rstack #(.RS_DEPTH(32), .DSZ(32), .ASZ(5)) dut (.clk(clk), .rst(rst), .rs(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".r"}, bus.r_o, q.size() ? q[$] : 32'h0);
    chk({tag, ".depth"}, 32'(bus.depth_o), q.size());
    chk({tag, ".z"}, 32'(bus.z_o), 32'(mz));
    chk({tag, ".ovf"}, 32'(bus.ovf_o), 32'(movf));
    chk({tag, ".udf"}, 32'(bus.udf_o), 32'(mudf));
  endtask
  task automatic step(input string tag, input logic e, input rs_op_t o, input logic [31:0] d);
    bus.en = e;
    bus.op = o;
    bus.d_i = d;
    @(posedge clk);
    #1;
    if (e) begin
      mz = 1'b0;
      case (o)
        rPUSH: if (q.size() == 32) movf = 1'b1; else q.push_back(d);
        rPOP:  if (q.size() == 0) mudf = 1'b1; else void'(q.pop_back());
        rDEC:  if (q.size() == 0) mudf = 1'b1;
               else if (q[$] != 0) q[$] = q[$] - 1;
               else begin
                 void'(q.pop_back());
                 mz = 1'b1;
               end
        rCLR:  q.delete();
        default: ;
      endcase
    end
    check_all(tag);
  endtask
  task automatic reset(input string tag);
    rst = 1'b1;
    bus.en = 1'b1;
    bus.op = rPUSH;
    bus.d_i = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mz = 1'b0;
    movf = 1'b0;
    mudf = 1'b0;
    chk({tag, ".r0"}, bus.r_o, 32'h0);
    chk({tag, ".d0"}, 32'(bus.depth_o), 32'h0);
    chk({tag, ".flags0"}, {29'h0, bus.z_o, bus.ovf_o, bus.udf_o}, 32'h0);
  endtask
  initial begin
    bus.en = 1'b0;
    bus.op = rNOP;
    bus.d_i = '0;
    reset("rst");
    step("p11", 1, rPUSH, 32'h11);
    step("p22", 1, rPUSH, 32'h22);
    step("p33", 1, rPUSH, 32'h33);
    chk("lifo.top", bus.r_o, 32'h33);
    step("pop1", 1, rPOP, 0);
    chk("lifo.pop1", bus.r_o, 32'h22);
    step("pop2", 1, rPOP, 0);
    chk("lifo.pop2", bus.r_o, 32'h11);
    step("pop3", 1, rPOP, 0);
    chk("lifo.pop3", bus.r_o, 32'h0);
    reset("rst2");
    for (int i = 1; i <= 32; i++) step("fill", 1, rPUSH, i);
    step("ovf", 1, rPUSH, 32'hDEAD);
    chk("ovf.flag", 32'(bus.ovf_o), 32'h1);
    chk("ovf.r", bus.r_o, 32'd32);
    chk("ovf.depth", 32'(bus.depth_o), 32'd32);
    for (int i = 32; i >= 1; i--) begin
      chk("drain.val", bus.r_o, i);
      step("drain", 1, rPOP, 0);
    end
    reset("rst3");
    step("udf.pop", 1, rPOP, 0);
    step("udf.dec", 1, rDEC, 0);
    chk("udf.flag", 32'(bus.udf_o), 32'h1);
    step("udf.p1", 1, rPUSH, 32'h5);
    step("udf.p2", 1, rPUSH, 32'h6);
    chk("udf.sticky", 32'(bus.udf_o), 32'h1);
    step("clr", 1, rCLR, 0);
    chk("clr.keep_udf", 32'(bus.udf_o), 32'h1);
    chk("clr.depth", 32'(bus.depth_o), 32'h0);
    reset("rst4");
    step("l.p100", 1, rPUSH, 32'h100);
    step("l.p2", 1, rPUSH, 32'h2);
    step("l.dec1", 1, rDEC, 0);
    chk("loop.r1", bus.r_o, 32'h1);
    step("l.dec2", 1, rDEC, 0);
    chk("loop.r0", bus.r_o, 32'h0);
    step("l.dec3", 1, rDEC, 0);
    chk("loop.z", 32'(bus.z_o), 32'h1);
    chk("loop.r", bus.r_o, 32'h100);
    chk("loop.depth", 32'(bus.depth_o), 32'h1);
    step("l.nop", 1, rNOP, 0);
    chk("loop.zclr", 32'(bus.z_o), 32'h0);
    step("l.p0", 1, rPUSH, 32'h0);
    step("l.dec4", 1, rDEC, 0);
    step("l.hold", 0, rNOP, 0);
    chk("loop.zhold", 32'(bus.z_o), 32'h1);
    reset("rst5");
    for (int i = 0; i < 5; i++) step("alt.fill", 1, rPUSH, 32'hA0 + i);
    for (int i = 0; i < 50; i++) step("alt", 1, (i % 2) ? rPOP : rPUSH, $urandom);
    chk("alt.depth", 32'(bus.depth_o), 32'd5);
    reset("rst6");
    for (int i = 0; i < 7; i++) step("mid.fill", 1, rPUSH, 32'h70 + i);
    chk("mid.depth7", 32'(bus.depth_o), 32'd7);
    reset("midrst");
    step("en0.p1", 1, rPUSH, 32'h1234);
    step("en0.push", 0, rPUSH, 32'h5678);
    chk("en0.r", bus.r_o, 32'h1234);
    chk("en0.depth", 32'(bus.depth_o), 32'd1);
    step("en0.pop", 1, rPOP, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
